// File: rtl/fetch_aligner.sv
// Instruction fetch aligner: buffers fetched words as halfwords and presents one
// right-aligned RVC or 32-bit instruction per handshake. Optional counters: FETCH_ALIGN_STATS_EN.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] f_addr_o,
  output logic        f_req_o,
  input  logic        f_gnt_i,
  input  logic [31:0] f_rdata_i,
  input  logic        f_rvalid_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] ins_o,
  output logic [31:0] ins_pc_o,
  output logic        ins_c_o,
  output logic        ins_valid_o,
  input  logic        ins_ready_i
`ifdef FETCH_ALIGN_STATS_EN
  ,
  output logic [31:0] cnt_c_o,
  output logic [31:0] cnt_w_o
`endif
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high at the clock edge; valid never depends on ready.

  logic [15:0] hb     [BUF_HW];
  logic [15:0] hb_nxt [BUF_HW];
  logic [15:0] hb_ext [BUF_HW+2];
  logic [2:0]  hcount, hcount_pop, hcount_nxt, pop_n;
  logic [31:0] head_pc, fetch_pc;
  logic        outstanding, kill, drop_lo;
  logic        head_c, pop, rsp, app_en;

  assign head_c = (hb[0][1:0] != 2'b11);

  always_comb begin
    ins_valid_o = head_c ? (hcount >= 3'd1) : (hcount >= 3'd2);
    ins_c_o     = ins_valid_o & head_c;
    ins_o       = '0;
    if (ins_valid_o) ins_o = head_c ? {16'h0000, hb[0]} : {hb[1], hb[0]};
  end

  assign ins_pc_o   = head_pc;
  assign pop        = ins_valid_o & ins_ready_i & ~redirect_i;
  assign pop_n      = pop ? (head_c ? 3'd1 : 3'd2) : 3'd0;
  assign hcount_pop = hcount - pop_n;
  // Requesting only at <=2 buffered halfwords guarantees room for the whole word.
  assign f_req_o    = ~rst & ~outstanding & ~redirect_i & (hcount_pop <= 3'd2);
  assign f_addr_o   = fetch_pc;
  assign rsp        = f_rvalid_i & outstanding;
  assign app_en     = rsp & ~kill;

  always_comb begin
    for (int i = 0; i < BUF_HW + 2; i++) begin
      hb_ext[i] = (i < BUF_HW) ? hb[i % BUF_HW] : 16'h0000;
    end
    for (int i = 0; i < BUF_HW; i++) begin
      hb_nxt[i] = hb[i];
      if (pop_n == 3'd1) hb_nxt[i] = hb_ext[i+1];
      if (pop_n == 3'd2) hb_nxt[i] = hb_ext[i+2];
      // Append lands on the post-pop fill level.
      if (app_en && hcount_pop == 3'(i))
        hb_nxt[i] = drop_lo ? f_rdata_i[31:16] : f_rdata_i[15:0];
      if (app_en && !drop_lo && hcount_pop == 3'(i - 1))
        hb_nxt[i] = f_rdata_i[31:16];
    end
    hcount_nxt = hcount_pop;
    if (app_en) hcount_nxt = hcount_pop + (drop_lo ? 3'd1 : 3'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_HW; i++) hb[i] <= 16'h0000;
      hcount      <= 3'd0;
      head_pc     <= RESET_PC;
      fetch_pc    <= RESET_PC & ~32'd3;
      outstanding <= 1'b0;
      kill        <= 1'b0;
      drop_lo     <= RESET_PC[1];
    end else if (redirect_i) begin
      hcount      <= 3'd0;
      head_pc     <= redirect_pc_i & ~32'd1;
      fetch_pc    <= redirect_pc_i & ~32'd3;
      drop_lo     <= redirect_pc_i[1];
      // A response arriving right now is simply dropped; otherwise squash the next one.
      kill        <= outstanding & ~f_rvalid_i;
      outstanding <= outstanding & ~f_rvalid_i;
    end else begin
      hb     <= hb_nxt;
      hcount <= hcount_nxt;
      if (pop) head_pc <= head_pc + (head_c ? 32'd2 : 32'd4);
      if (rsp) begin
        outstanding <= 1'b0;
        if (kill) kill <= 1'b0;
        else if (drop_lo) drop_lo <= 1'b0;
      end
      if (f_req_o && f_gnt_i) begin
        outstanding <= 1'b1;
        fetch_pc    <= fetch_pc + 32'd4;
      end
    end
  end

`ifdef FETCH_ALIGN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_c_o <= '0;
      cnt_w_o <= '0;
    end else if (pop) begin
      if (head_c) cnt_c_o <= cnt_c_o + 32'd1;
      else        cnt_w_o <= cnt_w_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Instruction-fetch stage directly upstream of the compressed-instruction expander.
- Fetches word-aligned 32-bit words from instruction memory and buffers them as halfwords.
- Presents exactly one instruction per handshake, right-aligned: a 16-bit RVC instruction zero-extended, or a full 32-bit instruction, including 32-bit instructions that straddle a word boundary.
- Tracks the instruction PC and handles branch/jump redirects with in-flight response squashing.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch PC after reset (bit 0 must be 0).
- BUF_HW, 4, halfword buffer depth (fixed at 4; other values unsupported).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- f_addr_o  out  32  fetch word address, bits [1:0] always 0
- f_req_o  out  1  fetch request valid
- f_gnt_i  in  1  memory accepts request this cycle
- f_rdata_i  in  32  fetch response data
- f_rvalid_i  in  1  response valid; responses return in order, one at a time
- redirect_i  in  1  flush and restart fetch
- redirect_pc_i  in  32  new PC, halfword aligned; bit 0 ignored
- ins_o  out  32  aligned instruction
- ins_pc_o  out  32  PC of ins_o
- ins_c_o  out  1  1 = 16-bit instruction, zero-extended in ins_o
- ins_valid_o  out  1  ins_o valid
- ins_ready_i  in  1  downstream accepts

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk. On reset:
  - hcount=0, head_pc=RESET_PC, fetch_pc=RESET_PC&~3, outstanding=0, kill=0, drop_lo=RESET_PC[1].
  - Outputs: f_req_o=0, ins_valid_o=0, ins_o=0, ins_pc_o=RESET_PC, ins_c_o=0.
- Buffer: hb[0..3] halfwords with hcount 0..4; hb[0] is the oldest halfword.
- Fetch request:
  - f_req_o=1 when !outstanding and hcount<=2 after this cycle's pop, and !redirect_i.
  - f_addr_o=fetch_pc.
  - On f_req_o&&f_gnt_i: outstanding=1, fetch_pc+=4.
- Response (f_rvalid_i&&outstanding): outstanding=0.
  - kill=1: discard data, clear kill.
  - Else append {hi,lo} halfwords, lo first.
  - drop_lo=1: append only hi, clear drop_lo.
  - Buffer write is registered; the instruction becomes visible the cycle after f_rvalid_i.
- Output (combinational from the buffer head):
  - hcount>=1 and hb[0][1:0]!=2'b11 → ins_valid_o=1, ins_c_o=1, ins_o={16'h0,hb[0]}.
  - hcount>=2 and hb[0][1:0]==2'b11 → ins_valid_o=1, ins_c_o=0, ins_o={hb[1],hb[0]}.
  - Otherwise ins_valid_o=0: empty buffer, or only the lower half of a straddling 32-bit instruction present.
  - ins_pc_o=head_pc.
- Pop on ins_valid_o&&ins_ready_i: remove 1 (compressed) or 2 halfwords; head_pc += 2 or 4, wrapping modulo 2^32.
- Pop and append in the same cycle: shift first, then append at the post-pop hcount. Never overflows, because a request is issued only when hcount<=2.
- Redirect (highest priority):
  - Same-cycle pop is ignored.
  - hcount=0, head_pc={redirect_pc_i[31:1],1'b0}, fetch_pc=redirect_pc_i&~3, drop_lo=redirect_pc_i[1].
  - kill=outstanding, unless f_rvalid_i is also high this cycle: that response is discarded directly and kill=0.
  - f_req_o is forced 0 in the redirect cycle; the first request goes out the next cycle.
  - Minimum redirect-to-ins_valid_o latency: 3 cycles with a 1-cycle memory.
- Back-to-back redirects: the last one wins; at most one kill is pending, because only one request is ever outstanding.
- Reset mid-transaction: all state cleared; a late f_rvalid_i with outstanding=0 is ignored.

Optional Feature:
- Macro: FETCH_ALIGN_STATS_EN.
- Defined:
  - Adds output ports cnt_c_o[31:0] and cnt_w_o[31:0].
  - They count accepted compressed and 32-bit instructions respectively; reset to 0, wrap at 2^32.
  - Not incremented in a redirect cycle.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, memory returns 32'h00A00093 at addr 0 → f_addr_o=0; next cycle ins_valid_o=1, ins_o=32'h00A00093, ins_c_o=0, ins_pc_o=0.
- Word 32'h4501_0505 at addr 0 → two pops: ins_o=32'h0000_0505 pc=0, then 32'h0000_4501 pc=2, both ins_c_o=1.
- Straddle: word0=32'h0093_0505, word1=32'h4501_00A0 → 0x0505 (pc 0), then 32'h00A0_0093 (pc 2, ins_c_o=0), then 0x4501 (pc 6); ins_valid_o=0 while only word0 is buffered.
- Redirect to 32'h0000_0102 while a response is outstanding → that response is discarded; next f_addr_o=32'h100; the low halfword of the returned word is dropped; first ins_pc_o=32'h102.
- ins_ready_i held 0 for 10 cycles → hcount saturates at 4, f_req_o=0, ins_o stable; on release fetching resumes with no halfword lost or duplicated.
- With FETCH_ALIGN_STATS_EN, deliver 3 compressed and 2 32-bit instructions, with one redirect cycle coinciding with ins_ready_i=1 → cnt_c_o=3, cnt_w_o=2.
